// File: rtl/fetch_stage_pkg.sv
// Shared types for the instruction-fetch stage: FSM encoding, IF/ID entry layout, defaults.
package fetch_stage_pkg;

  localparam int          INSTR_WIDTH      = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_FETCH = 2'd1,
    FS_DRAIN = 2'd2,
    FS_HOLD  = 2'd3
  } fs_state_t;

  typedef struct packed {
    logic [31:0]            pc;
    logic [INSTR_WIDTH-1:0] instr;
  } fetch_dat_t;

  typedef struct packed {
    logic                   valid;
    logic [31:0]            pc;
    logic [INSTR_WIDTH-1:0] instr;
  } ifid_t;

endpackage

// File: rtl/fetch_stage_out_reg.sv
// IF/ID boundary register: flush beats load beats hold; with none of them the entry becomes a bubble.
// Flush and bubble clear only the valid bit so pc/instr keep their last values.
module fetch_out_reg
  import fetch_stage_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       flush,
  input  logic       hold,
  input  fetch_dat_t load_dat,
  output ifid_t      ifid
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ifid <= '0;
    end else if (flush) begin
      ifid.valid <= 1'b0;
    end else if (load) begin
      ifid <= {1'b1, load_dat};
    end else if (!hold) begin
      ifid.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, runs a one-outstanding req/ack handshake to instruction memory,
// parks a fetched word in a skid buffer while decode is frozen, and drains in-flight fetches on redirect.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          PC_STEP  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   freeze,
  input  logic                   branch_taken,
  input  logic [31:0]            branch_addr,
  output logic                   imem_req,
  output logic [31:0]            imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   if_valid,
  output logic [31:0]            if_pc,
  output logic [INSTR_WIDTH-1:0] if_instr
);

  fs_state_t   state, state_nxt;
  logic [31:0] pc, pc_nxt, pc_inc;
  logic [31:0] pc_pending, pc_pending_nxt;
  fetch_dat_t  skid, skid_nxt;
  fetch_dat_t  ld_dat;
  logic        ld, fl, hd;
  ifid_t       ifid;

  assign pc_inc    = pc + 32'(PC_STEP);
  assign imem_addr = pc;
  assign imem_req  = (state == FS_FETCH) || (state == FS_DRAIN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= FS_IDLE;
      pc         <= RESET_PC;
      pc_pending <= '0;
      skid       <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      pc_pending <= pc_pending_nxt;
      skid       <= skid_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    pc_pending_nxt = pc_pending;
    skid_nxt       = skid;
    ld             = 1'b0;
    fl             = 1'b0;
    hd             = freeze;
    ld_dat         = {pc_inc, imem_rdata};

    unique case (state)
      FS_IDLE: begin
        hd        = 1'b1;
        state_nxt = FS_FETCH;
      end

      FS_FETCH: begin
        if (branch_taken) begin
          fl = 1'b1;
          if (imem_ack) begin
            pc_nxt = branch_addr;
          end else begin
            // Request is still in flight; it must complete at the old address first.
            pc_pending_nxt = branch_addr;
            state_nxt      = FS_DRAIN;
          end
        end else if (imem_ack) begin
          pc_nxt = pc_inc;
          if (freeze) begin
            skid_nxt  = {pc_inc, imem_rdata};
            state_nxt = FS_HOLD;
          end else begin
            ld = 1'b1;
          end
        end
      end

      FS_DRAIN: begin
        fl = 1'b1;
        if (branch_taken) begin
          pc_pending_nxt = branch_addr;
        end
        if (imem_ack) begin
          pc_nxt    = branch_taken ? branch_addr : pc_pending;
          state_nxt = FS_FETCH;
        end
      end

      FS_HOLD: begin
        if (branch_taken) begin
          fl        = 1'b1;
          pc_nxt    = branch_addr;
          state_nxt = FS_FETCH;
        end else if (!freeze) begin
          ld        = 1'b1;
          ld_dat    = skid;
          state_nxt = FS_FETCH;
        end
      end

      default: state_nxt = FS_IDLE;
    endcase
  end

  fetch_out_reg u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (ld),
    .flush    (fl),
    .hold     (hd),
    .load_dat (ld_dat),
    .ifid     (ifid)
  );

  assign if_valid = ifid.valid;
  assign if_pc    = ifid.pc;
  assign if_instr = ifid.instr;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-programmable instruction memory returning 0xE0000000+addr.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  logic        mem_en;
  int          mem_lat;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_busy;
  int          mem_wait;
  logic        tb_ack;
  logic [31:0] tb_rdata;

  int n_checks = 0;
  int n_errors = 0;

  assign imem_ack   = mem_ack | tb_ack;
  assign imem_rdata = tb_ack ? tb_rdata : mem_rdata;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_instr     (if_instr)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory: a request seen while idle is acked mem_lat cycles later for one cycle.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    mem_busy  = 1'b0;
    mem_wait  = 0;
    forever begin
      tick();
      if (!mem_en) begin
        mem_busy = 1'b0;
        mem_ack  = 1'b0;
      end else if (mem_ack) begin
        mem_ack  = 1'b0;
        mem_busy = 1'b0;
        if (imem_req) begin
          mem_busy = 1'b1;
          mem_wait = mem_lat;
        end
      end else if (mem_busy) begin
        mem_wait--;
        if (mem_wait == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = 32'hE000_0000 + imem_addr;
        end
      end else if (imem_req) begin
        mem_busy = 1'b1;
        mem_wait = mem_lat;
      end
    end
  end

  initial begin
    rst          = 1'b0;
    freeze       = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = '0;
    mem_en       = 1'b1;
    mem_lat      = 1;
    tb_ack       = 1'b0;
    tb_rdata     = '0;
    #1;
    check_val("rst_valid", {31'b0, if_valid}, 32'd0);
    check_val("rst_pc",    if_pc,    32'd0);
    check_val("rst_instr", if_instr, 32'd0);
    check_val("rst_req",   {31'b0, imem_req}, 32'd0);
    check_val("rst_addr",  imem_addr, 32'd0);

    // Sequential fetch at 1-cycle memory latency
    @(negedge clk) rst = 1'b1;
    tick();                                                   // t1
    check_val("t1_req",  {31'b0, imem_req}, 32'd1);
    check_val("t1_addr", imem_addr, 32'd0);
    tick();                                                   // t2
    check_val("t2_valid", {31'b0, if_valid}, 32'd0);
    tick();                                                   // t3
    check_val("t3_valid", {31'b0, if_valid}, 32'd1);
    check_val("t3_pc",    if_pc,    32'd4);
    check_val("t3_instr", if_instr, 32'hE000_0000);
    check_val("t3_addr",  imem_addr, 32'd4);
    tick();                                                   // t4
    check_val("t4_valid", {31'b0, if_valid}, 32'd0);
    tick();                                                   // t5
    check_val("t5_valid", {31'b0, if_valid}, 32'd1);
    check_val("t5_pc",    if_pc,    32'd8);
    check_val("t5_instr", if_instr, 32'hE000_0004);
    check_val("t5_addr",  imem_addr, 32'd8);

    // Freeze across the ack of addr 8
    freeze = 1'b1;
    tick();                                                   // t6
    check_val("frz_valid", {31'b0, if_valid}, 32'd1);
    for (int i = 7; i <= 10; i++) begin
      tick();
      check_val("hold_req",   {31'b0, imem_req}, 32'd0);
      check_val("hold_pc",    if_pc,    32'd8);
      check_val("hold_instr", if_instr, 32'hE000_0004);
    end
    freeze = 1'b0;
    tick();                                                   // t11
    check_val("unfrz_valid", {31'b0, if_valid}, 32'd1);
    check_val("unfrz_pc",    if_pc,    32'd12);
    check_val("unfrz_instr", if_instr, 32'hE000_0008);
    check_val("unfrz_req",   {31'b0, imem_req}, 32'd1);
    check_val("unfrz_addr",  imem_addr, 32'd12);

    // Branch coincident with ack at addr 12
    tick();                                                   // t12 (ack visible)
    branch_taken = 1'b1;
    branch_addr  = 32'h200;
    tick();                                                   // t13
    branch_taken = 1'b0;
    check_val("bra_valid", {31'b0, if_valid}, 32'd0);
    check_val("bra_pc",    if_pc, 32'd12);
    check_val("bra_addr",  imem_addr, 32'h200);
    tick();                                                   // t14
    mem_lat = 3;
    tick();                                                   // t15
    check_val("b200_valid", {31'b0, if_valid}, 32'd1);
    check_val("b200_pc",    if_pc,    32'h204);
    check_val("b200_instr", if_instr, 32'hE000_0200);

    // Branch while a 3-cycle fetch of 0x204 is pending
    tick();                                                   // t16
    branch_taken = 1'b1;
    branch_addr  = 32'h100;
    tick();                                                   // t17
    branch_taken = 1'b0;
    check_val("drn_valid", {31'b0, if_valid}, 32'd0);
    check_val("drn_req",   {31'b0, imem_req}, 32'd1);
    check_val("drn_addr",  imem_addr, 32'h204);
    tick();                                                   // t18
    check_val("drn2_addr",  imem_addr, 32'h204);
    check_val("drn2_valid", {31'b0, if_valid}, 32'd0);
    tick();                                                   // t19
    check_val("drn_done_addr",  imem_addr, 32'h100);
    check_val("drn_done_valid", {31'b0, if_valid}, 32'd0);

    // Two redirects during DRAIN; the latest wins
    branch_taken = 1'b1;
    branch_addr  = 32'h40;
    tick();                                                   // t20
    branch_addr  = 32'h80;
    tick();                                                   // t21
    branch_taken = 1'b0;
    check_val("dbl_addr",  imem_addr, 32'h100);
    check_val("dbl_valid", {31'b0, if_valid}, 32'd0);
    tick();                                                   // t22
    mem_lat = 1;
    tick();                                                   // t23
    check_val("dbl_target", imem_addr, 32'h80);
    check_val("dbl_valid2", {31'b0, if_valid}, 32'd0);
    tick();                                                   // t24
    tick();                                                   // t25
    check_val("b80_pc", if_pc, 32'h84);

    // Redirect to the last word of the address space and wrap
    tick();                                                   // t26
    branch_taken = 1'b1;
    branch_addr  = 32'hFFFF_FFFC;
    tick();                                                   // t27
    branch_taken = 1'b0;
    check_val("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    tick();                                                   // t28
    mem_lat = 3;
    tick();                                                   // t29
    check_val("wrap_valid", {31'b0, if_valid}, 32'd1);
    check_val("wrap_pc",    if_pc,    32'd0);
    check_val("wrap_instr", if_instr, 32'hDFFF_FFFC);
    check_val("wrap_next",  imem_addr, 32'd0);

    // Asynchronous reset while a fetch is waiting; late ack must be ignored
    tick();                                                   // t30
    check_val("wait_req", {31'b0, imem_req}, 32'd1);
    @(negedge clk);
    rst    = 1'b0;
    mem_en = 1'b0;
    #1;
    check_val("arst_valid", {31'b0, if_valid}, 32'd0);
    check_val("arst_pc",    if_pc,    32'd0);
    check_val("arst_instr", if_instr, 32'd0);
    check_val("arst_req",   {31'b0, imem_req}, 32'd0);
    check_val("arst_addr",  imem_addr, 32'd0);
    tb_ack   = 1'b1;
    tb_rdata = 32'h1234_5678;
    tick();
    check_val("late_in_rst_valid", {31'b0, if_valid}, 32'd0);
    @(negedge clk) rst = 1'b1;
    tick();
    tb_ack = 1'b0;
    check_val("late_idle_valid", {31'b0, if_valid}, 32'd0);
    check_val("late_idle_req",   {31'b0, imem_req}, 32'd1);
    check_val("late_idle_addr",  imem_addr, 32'd0);
    tick();
    check_val("late_idle_valid2", {31'b0, if_valid}, 32'd0);
    check_val("late_idle_pc",     if_pc, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
